composite_memory_bist: RTL and testbench
========================================

// Module: composite_memory_bist
// PURPOSE
// Built-in self-test initiator for the 4-bank composite memory (we/addr/din/dout
// port). On a start pulse it writes an address-derived pattern over a programmable
// address window, reads it back, and compares each word. It reports pass/fail,
// the first failing address/data and a saturating error count. It sits between
// system control and the memory's single access port.
// PARAMETERS
// ADDR_W     16       memory address width
// DATA_W     8        memory data width
// RD_LAT     1        memory read latency in cycles (addr sampled -> dout valid)
// START_ADDR 16'h0000 first address tested
// END_ADDR   16'hFFFF last address tested (inclusive)
// SEED       8'h5A    pattern seed
// PORTS
// clk        in  1       system clock, rising edge
// rst        in  1       asynchronous reset, active-high
// start      in  1       start request, sampled only in IDLE
// busy       out 1       high from the cycle after start until done
// done       out 1       one-cycle completion pulse
// pass       out 1       1 = no mismatch in last run; held until next start
// err_count  out 8       mismatch count, saturates at 8'hFF
// fail_addr  out ADDR_W  address of first mismatch (0 if none)
// fail_data  out DATA_W  dout captured at first mismatch (0 if none)
// mem_we     out 1       memory write enable
// mem_addr   out ADDR_W  memory address
// mem_din    out DATA_W  memory write data
// mem_dout   in  DATA_W  memory read data
// BEHAVIOUR
// - Reset (async): state IDLE; every output 0 except pass=1; the compare pipeline is cleared.
// - pat(a) = a[7:0] ^ a[15:8] ^ SEED. N = END_ADDR-START_ADDR+1 words.
// - FSM: IDLE -> WRITE -> READ -> DRAIN -> DONE -> IDLE. All outputs registered.
// - IDLE: start=1 at edge E0 -> WRITE. Clears err_count/fail_*; pass=1; busy=1.
//   mem_addr=START_ADDR, mem_we=1, mem_din=pat(START_ADDR).
// - WRITE: one word per cycle. At mem_addr==END_ADDR -> READ. mem_we=0, mem_addr=START_ADDR.
// - READ: one address per cycle, mem_we=0. The expected value is pushed into an
//   RD_LAT+1 deep pipeline. At END_ADDR -> DRAIN.
// - A word whose address is driven from edge K is compared at edge K+1+RD_LAT.
// - DRAIN: lasts until the last word is compared, then -> DONE.
// - DONE: done=1 and busy=0 for exactly one cycle, then -> IDLE.
// - Done rises at edge E0+2N+RD_LAT+1.
// - Mismatch: pass<=0; err_count+1 (saturating). fail_addr/fail_data are captured on
//   the first mismatch only.
// - Address counter compares against END_ADDR before incrementing, so END_ADDR=16'hFFFF
//   never wraps to 0.
// - END_ADDR < START_ADDR: no memory access; start -> DONE next cycle with pass=1.
// - start while busy is ignored. start held high re-triggers only after returning to IDLE.
// - rst mid-run: mem_we drops immediately, the run is abandoned, and no done pulse is issued.
// CONFIGURATION
// BIST_INVERT_PASS_EN defined: after the first read-back, a second WRITE/READ/DRAIN
//   pass runs with ~pat(a). Done rises at E0+4N+2*(RD_LAT+1). The error
//   counter/first-fail capture span both passes.
// BIST_INVERT_PASS_EN undefined: single pass only, timing as above.
// TESTING
// 1. Window 0x0000-0x000F, RD_LAT=1, good memory, start at E0 -> 16 writes
//    (0x0000<-5A, 0x000F<-55); done at E0+34; pass=1; err_count=0.
// 2. Same window with word 0x0003 stuck at 00 -> pass=0, err_count=1,
//    fail_addr=0x0003, fail_data=00.
// 3. Window 0x4000-0x4001 crossing a bank boundary -> writes 0x4000<-1A,
//    0x4001<-1B; both read back OK; pass=1.
// 4. Window 0xFFFE-0xFFFF -> mem_addr never shows 0x0000 after 0xFFFF; done at E0+6.
// 5. rst pulsed mid-WRITE -> mem_we=0 the same cycle; all outputs at reset values;
//    no done; a new start runs a full pass.
// 6. With BIST_INVERT_PASS_EN, window 0x0000-0x0001 -> second pass writes A5,A4;
//    done at E0+12; pass=1.

Source files
------------

// File: rtl/composite_memory_bist_if.sv
// Control/status and single memory-port bundle for composite_memory_bist.
// The master side is the BIST engine; the slave side is system control plus the memory.
interface composite_memory_bist_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);
  logic              start;
  logic              busy;
  logic              done;
  logic              pass;
  logic [7:0]        err_count;
  logic [ADDR_W-1:0] fail_addr;
  logic [DATA_W-1:0] fail_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport master (
    input  start, mem_dout,
    output busy, done, pass, err_count, fail_addr, fail_data, mem_we, mem_addr, mem_din
  );

  modport slave (
    output start, mem_dout,
    input  busy, done, pass, err_count, fail_addr, fail_data, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/composite_memory_bist.sv
// Write/read-back BIST over [START_ADDR, END_ADDR] with an address-derived pattern.
// Define BIST_INVERT_PASS_EN to add a second pass using the inverted pattern.
module composite_memory_bist #(
  parameter int unsigned       ADDR_W     = 16,
  parameter int unsigned       DATA_W     = 8,
  parameter int unsigned       RD_LAT     = 1,
  parameter logic [ADDR_W-1:0] START_ADDR = 16'h0000,
  parameter logic [ADDR_W-1:0] END_ADDR   = 16'hFFFF,
  parameter logic [DATA_W-1:0] SEED       = 8'h5A
) (
  input  logic                   clk,
  input  logic                   rst,
  composite_memory_bist_if.master bus
);
  localparam bit          Empty = (END_ADDR < START_ADDR);
  localparam int unsigned CntW  = $clog2(RD_LAT + 2);

  typedef enum logic [2:0] {StIdle, StWrite, StRead, StDrain, StDone} state_e;
  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              we_q, we_d, busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [7:0]        err_q, err_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0] fail_data_q, fail_data_d;
  logic              inv_q, inv_d, push;
  logic [CntW-1:0]   cnt_q, cnt_d;

  // Expected-data pipeline; stage RD_LAT lines up with mem_dout.
  logic              pipe_v_q [RD_LAT+1];
  logic [ADDR_W-1:0] pipe_a_q [RD_LAT+1];
  logic [DATA_W-1:0] pipe_e_q [RD_LAT+1];

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a, input logic inv);
    logic [15:0]       a16;
    logic [DATA_W-1:0] p;
    a16 = 16'(a);
    p   = DATA_W'(a16[7:0] ^ a16[15:8]) ^ SEED;
    return inv ? ~p : p;
  endfunction

  logic              last_word, drain_end;
  logic [ADDR_W-1:0] addr_inc;
  assign last_word = (addr_q == END_ADDR);
  assign drain_end = (cnt_q == CntW'(RD_LAT));
  assign addr_inc  = addr_q + ADDR_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (bus.start) state_d = Empty ? StDone : StWrite;
      StWrite: if (last_word) state_d = StRead;
      StRead:  if (last_word) state_d = StDrain;
      StDrain: begin
        if (drain_end) begin
`ifdef BIST_INVERT_PASS_EN
          state_d = inv_q ? StDone : StWrite;
`else
          state_d = StDone;
`endif
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    addr_d      = addr_q;
    we_d        = 1'b0;
    din_d       = din_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_d       = err_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    inv_d       = inv_q;
    cnt_d       = '0;
    push        = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          pass_d      = 1'b1;
          err_d       = '0;
          fail_addr_d = '0;
          fail_data_d = '0;
          inv_d       = 1'b0;
          if (Empty) begin
            done_d = 1'b1;
          end else begin
            busy_d = 1'b1;
            we_d   = 1'b1;
            addr_d = START_ADDR;
            din_d  = pat(START_ADDR, 1'b0);
          end
        end
      end
      StWrite: begin
        if (last_word) begin
          addr_d = START_ADDR;
          push   = 1'b1;
        end else begin
          addr_d = addr_inc;
          we_d   = 1'b1;
          din_d  = pat(addr_inc, inv_q);
        end
      end
      StRead: begin
        // Hold on END_ADDR so a full-range window never wraps back to 0.
        if (!last_word) begin
          addr_d = addr_inc;
          push   = 1'b1;
        end
      end
      StDrain: begin
        cnt_d = cnt_q + CntW'(1);
        if (drain_end) begin
`ifdef BIST_INVERT_PASS_EN
          if (!inv_q) begin
            inv_d  = 1'b1;
            we_d   = 1'b1;
            addr_d = START_ADDR;
            din_d  = pat(START_ADDR, 1'b1);
          end else begin
            done_d = 1'b1;
            busy_d = 1'b0;
          end
`else
          done_d = 1'b1;
          busy_d = 1'b0;
`endif
        end
      end
      default: ;
    endcase
    if (pipe_v_q[RD_LAT] && (bus.mem_dout != pipe_e_q[RD_LAT])) begin
      pass_d = 1'b0;
      if (err_q != 8'hFF) err_d = err_q + 8'd1;
      if (err_q == 8'h00) begin
        fail_addr_d = pipe_a_q[RD_LAT];
        fail_data_d = bus.mem_dout;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      we_q        <= 1'b0;
      din_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b1;
      err_q       <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      inv_q       <= 1'b0;
      cnt_q       <= '0;
      for (int unsigned i = 0; i <= RD_LAT; i++) begin
        pipe_v_q[i] <= 1'b0;
        pipe_a_q[i] <= '0;
        pipe_e_q[i] <= '0;
      end
    end else begin
      addr_q      <= addr_d;
      we_q        <= we_d;
      din_q       <= din_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      inv_q       <= inv_d;
      cnt_q       <= cnt_d;
      pipe_v_q[0] <= push;
      pipe_a_q[0] <= addr_d;
      pipe_e_q[0] <= pat(addr_d, inv_q);
      for (int unsigned i = 1; i <= RD_LAT; i++) begin
        pipe_v_q[i] <= pipe_v_q[i-1];
        pipe_a_q[i] <= pipe_a_q[i-1];
        pipe_e_q[i] <= pipe_e_q[i-1];
      end
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_din   = din_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.fail_addr = fail_addr_q;
  assign bus.fail_data = fail_data_q;
endmodule

// File: tb/tb_composite_memory_bist.sv
// Directed bench for composite_memory_bist: four windows, stuck-at fault, mid-run reset.
module tb_composite_memory_bist;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef BIST_INVERT_PASS_EN
  localparam int DoneA = 68;
  localparam int DoneC = 12;
  localparam int ErrF  = 2;
`else
  localparam int DoneA = 34;
  localparam int DoneC = 6;
  localparam int ErrF  = 1;
`endif

  composite_memory_bist_if #(.ADDR_W(16), .DATA_W(8)) a_if ();
  composite_memory_bist_if #(.ADDR_W(16), .DATA_W(8)) c_if ();
  composite_memory_bist_if #(.ADDR_W(16), .DATA_W(8)) d_if ();
  composite_memory_bist_if #(.ADDR_W(16), .DATA_W(8)) e_if ();

  composite_memory_bist #(.START_ADDR(16'h0000), .END_ADDR(16'h000F)) u_a (
    .clk(clk), .rst(rst), .bus(a_if));
  composite_memory_bist #(.START_ADDR(16'h4000), .END_ADDR(16'h4001)) u_c (
    .clk(clk), .rst(rst), .bus(c_if));
  composite_memory_bist #(.START_ADDR(16'hFFFE), .END_ADDR(16'hFFFF)) u_d (
    .clk(clk), .rst(rst), .bus(d_if));
  composite_memory_bist #(.START_ADDR(16'h0010), .END_ADDR(16'h000F)) u_e (
    .clk(clk), .rst(rst), .bus(e_if));

  logic start_a, start_c, start_d, start_e, fault_a;
  assign a_if.start    = start_a;
  assign c_if.start    = start_c;
  assign d_if.start    = start_d;
  assign e_if.start    = start_e;
  assign e_if.mem_dout = 8'h00;

  logic [7:0] mem_a [0:65535];
  logic [7:0] mem_c [0:65535];
  logic [7:0] mem_d [0:65535];

  // One-cycle read latency memories; word 0x0003 of mem_a can read back stuck at 00.
  always @(posedge clk) begin
    if (a_if.mem_we) mem_a[a_if.mem_addr] <= a_if.mem_din;
    a_if.mem_dout <= (fault_a && a_if.mem_addr == 16'h0003) ? 8'h00 : mem_a[a_if.mem_addr];
    if (c_if.mem_we) mem_c[c_if.mem_addr] <= c_if.mem_din;
    c_if.mem_dout <= mem_c[c_if.mem_addr];
    if (d_if.mem_we) mem_d[d_if.mem_addr] <= d_if.mem_din;
    d_if.mem_dout <= mem_d[d_if.mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic done_of(input int w);
    case (w)
      0:       return a_if.done;
      1:       return c_if.done;
      2:       return d_if.done;
      default: return e_if.done;
    endcase
  endfunction

  task automatic set_start(input int w, input logic v);
    case (w)
      0:       start_a = v;
      1:       start_c = v;
      2:       start_d = v;
      default: start_e = v;
    endcase
  endtask

  // Leaves the bench at the falling edge after the sampling edge E0.
  task automatic kick(input int w);
    set_start(w, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_start(w, 1'b0);
  endtask

  // Returns cycles until done (0 on timeout); also watches d_if.mem_addr for 0x0000.
  task automatic run_wait(input int w, output int cyc, output bit zero_seen);
    cyc       = 0;
    zero_seen = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (d_if.mem_addr == 16'h0000) zero_seen = 1'b1;
      if (done_of(w)) begin
        cyc = i;
        break;
      end
    end
  endtask

  initial begin
    int cyc;
    bit zs;
    bit seen;
    rst = 1'b1;
    start_a = 1'b0; start_c = 1'b0; start_d = 1'b0; start_e = 1'b0;
    fault_a = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", a_if.busy, 0);
    chk("rst_done", a_if.done, 0);
    chk("rst_pass", a_if.pass, 1);
    chk("rst_err", a_if.err_count, 0);
    chk("rst_fail_addr", a_if.fail_addr, 0);
    chk("rst_fail_data", a_if.fail_data, 0);
    chk("rst_we", a_if.mem_we, 0);
    chk("rst_addr", a_if.mem_addr, 0);
    chk("rst_din", a_if.mem_din, 0);
    rst = 1'b0;
    @(negedge clk);

    // Good memory, 16-word window
    kick(0);
    chk("t1_busy", a_if.busy, 1);
    chk("t1_we0", a_if.mem_we, 1);
    chk("t1_addr0", a_if.mem_addr, 16'h0000);
    chk("t1_din0", a_if.mem_din, 8'h5A);
    repeat (15) @(negedge clk);
    chk("t1_addrF", a_if.mem_addr, 16'h000F);
    chk("t1_dinF", a_if.mem_din, 8'h55);
    chk("t1_weF", a_if.mem_we, 1);
    @(negedge clk);
    chk("t1_rd_we", a_if.mem_we, 0);
    chk("t1_rd_addr", a_if.mem_addr, 16'h0000);
    run_wait(0, cyc, zs);
    chk("t1_done_cycle", 16 + cyc, DoneA);
    chk("t1_pass", a_if.pass, 1);
    chk("t1_err", a_if.err_count, 0);
    chk("t1_busy_done", a_if.busy, 0);
    @(negedge clk);
    chk("t1_done_pulse", a_if.done, 0);

    // Stuck-at-00 at 0x0003, with start re-asserted while busy
    fault_a = 1'b1;
    kick(0);
    start_a = 1'b1;
    repeat (4) @(negedge clk);
    start_a = 1'b0;
    chk("t2_busy", a_if.busy, 1);
    run_wait(0, cyc, zs);
    chk("t2_done_cycle", 4 + cyc, DoneA);
    chk("t2_pass", a_if.pass, 0);
    chk("t2_err", a_if.err_count, ErrF);
    chk("t2_fail_addr", a_if.fail_addr, 16'h0003);
    chk("t2_fail_data", a_if.fail_data, 8'h00);
    @(negedge clk);
    chk("t2_pass_held", a_if.pass, 0);
    fault_a = 1'b0;

    // Bank-boundary window
    kick(1);
    chk("t3_addr0", c_if.mem_addr, 16'h4000);
    chk("t3_din0", c_if.mem_din, 8'h1A);
    @(negedge clk);
    chk("t3_addr1", c_if.mem_addr, 16'h4001);
    chk("t3_din1", c_if.mem_din, 8'h1B);
    chk("t3_we1", c_if.mem_we, 1);
`ifdef BIST_INVERT_PASS_EN
    repeat (5) @(negedge clk);
    chk("t6_inv_din0", c_if.mem_din, 8'hE5);
    chk("t6_inv_we0", c_if.mem_we, 1);
    @(negedge clk);
    chk("t6_inv_din1", c_if.mem_din, 8'hE4);
    run_wait(1, cyc, zs);
    chk("t3_done_cycle", 7 + cyc, DoneC);
`else
    run_wait(1, cyc, zs);
    chk("t3_done_cycle", 1 + cyc, DoneC);
`endif
    chk("t3_pass", c_if.pass, 1);
    chk("t3_err", c_if.err_count, 0);
    @(negedge clk);

    // Top-of-range window must not wrap
    kick(2);
    chk("t4_addr0", d_if.mem_addr, 16'hFFFE);
    chk("t4_din0", d_if.mem_din, 8'h5B);
    @(negedge clk);
    chk("t4_addr1", d_if.mem_addr, 16'hFFFF);
    chk("t4_din1", d_if.mem_din, 8'h5A);
    run_wait(2, cyc, zs);
    chk("t4_done_cycle", 1 + cyc, DoneC);
    chk("t4_no_wrap", zs, 0);
    chk("t4_pass", d_if.pass, 1);
    @(negedge clk);
    chk("t4_addr_idle", d_if.mem_addr, 16'hFFFF);

    // Empty window
    kick(3);
    chk("t7_done", e_if.done, 1);
    chk("t7_busy", e_if.busy, 0);
    chk("t7_pass", e_if.pass, 1);
    chk("t7_we", e_if.mem_we, 0);
    @(negedge clk);
    chk("t7_done_pulse", e_if.done, 0);

    // Reset mid-WRITE
    kick(0);
    repeat (4) @(negedge clk);
    chk("t5_we_pre", a_if.mem_we, 1);
    chk("t5_addr_pre", a_if.mem_addr, 16'h0004);
    rst = 1'b1;
    #1;
    chk("t5_we", a_if.mem_we, 0);
    chk("t5_addr", a_if.mem_addr, 0);
    chk("t5_din", a_if.mem_din, 0);
    chk("t5_busy", a_if.busy, 0);
    chk("t5_pass", a_if.pass, 1);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (a_if.done) seen = 1'b1;
    end
    chk("t5_no_done", seen, 0);
    chk("t5_idle_we", a_if.mem_we, 0);
    kick(0);
    run_wait(0, cyc, zs);
    chk("t5_rerun_done", cyc, DoneA);
    chk("t5_rerun_pass", a_if.pass, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
